// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Forwarding and hazard logic are built only when FORWARDING_EN is defined.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [2:0]      alucontrol_d,
  input  logic            alusrc_d,
  input  logic [5:0]      ctrl_d,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [XLEN-1:0] result_w,
  input  logic [4:0]      rd_m,
  input  logic [4:0]      rd_w,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  output logic [XLEN-1:0] srca_e,
  output logic [XLEN-1:0] srcb_e,
  output logic [2:0]      alucontrol_e,
  output logic [5:0]      ctrl_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] writedata_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [XLEN-1:0] pctarget_e,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            loaduse_stall
);

  logic [XLEN-1:0] rd1_e, rd2_e, imm_e;
  logic [4:0]      rs1_e, rs2_e;
  logic            alusrc_e;

  // Flush wins over stall so a stalled slot can still be turned into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_e        <= '0;
      pc_e         <= '0;
      pcplus4_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      alucontrol_e <= '0;
      alusrc_e     <= 1'b0;
      ctrl_e       <= '0;
    end else if (flush_e) begin
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_e        <= '0;
      pc_e         <= '0;
      pcplus4_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      alucontrol_e <= '0;
      alusrc_e     <= 1'b0;
      ctrl_e       <= '0;
    end else if (!stall_e) begin
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      imm_e        <= imm_d;
      pc_e         <= pc_d;
      pcplus4_e    <= pcplus4_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      alucontrol_e <= alucontrol_d;
      alusrc_e     <= alusrc_d;
      ctrl_e       <= ctrl_d;
    end
  end

  assign pctarget_e = pc_e + imm_e;
  assign srcb_e     = alusrc_e ? imm_e : writedata_e;

`ifdef FORWARDING_EN
  // MEM is checked first so the younger result wins on a double match.
  always_comb begin
    fwd_a = 2'b00;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
      fwd_a = 2'b10;
    else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
      fwd_b = 2'b10;
    else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
      fwd_b = 2'b01;
  end

  always_comb begin
    case (fwd_a)
      2'b10:   srca_e = aluresult_m;
      2'b01:   srca_e = result_w;
      default: srca_e = rd1_e;
    endcase
  end

  always_comb begin
    case (fwd_b)
      2'b10:   writedata_e = aluresult_m;
      2'b01:   writedata_e = result_w;
      default: writedata_e = rd2_e;
    endcase
  end

  // resultsrc == 01 marks a load whose data is not ready until after MEM.
  assign loaduse_stall = (ctrl_e[3:2] == 2'b01) && (rd_e != 5'd0) &&
                         ((rd_e == rs1_d) || (rd_e == rs2_d));
`else
  logic unused_fwd;

  assign fwd_a         = 2'b00;
  assign fwd_b         = 2'b00;
  assign srca_e        = rd1_e;
  assign writedata_e   = rd2_e;
  assign loaduse_stall = 1'b0;
  assign unused_fwd    = ^{aluresult_m, result_w, rd_m, rd_w, regwrite_m,
                           regwrite_w, rs1_e, rs2_e};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a cycle-level reference model of the pipeline slot.
module tb_id_ex_stage;

  localparam int XLEN = 32;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d, pc_d, pcplus4_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [2:0]      alucontrol_d;
  logic            alusrc_d;
  logic [5:0]      ctrl_d;
  logic            stall_e, flush_e;
  logic [XLEN-1:0] aluresult_m, result_w;
  logic [4:0]      rd_m, rd_w;
  logic            regwrite_m, regwrite_w;
  logic [XLEN-1:0] srca_e, srcb_e, writedata_e, pc_e, pcplus4_e, pctarget_e;
  logic [2:0]      alucontrol_e;
  logic [5:0]      ctrl_e;
  logic [4:0]      rd_e;
  logic [1:0]      fwd_a, fwd_b;
  logic            loaduse_stall;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d), .ctrl_d(ctrl_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .aluresult_m(aluresult_m), .result_w(result_w),
    .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e), .ctrl_e(ctrl_e),
    .rd_e(rd_e), .writedata_e(writedata_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
    .pctarget_e(pctarget_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .loaduse_stall(loaduse_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the instruction currently held in the EX slot.
  typedef struct {
    logic [XLEN-1:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      alu;
    logic            alusrc;
    logic [5:0]      ctrl;
  } slot_t;

  slot_t m;

  function automatic slot_t bubble();
    slot_t b;
    b.rd1 = '0; b.rd2 = '0; b.imm = '0; b.pc = '0; b.pcp4 = '0;
    b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.alu = '0; b.alusrc = 1'b0; b.ctrl = '0;
    return b;
  endfunction

  // Which producer, if any, owns the newest value of architectural register r.
  function automatic logic [1:0] source_of(input logic [4:0] r);
    if (!FWD || r == 5'd0) return 2'b00;
    if (regwrite_m && rd_m == r) return 2'b10;
    if (regwrite_w && rd_w == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [XLEN-1:0] value_of(input logic [1:0] src, input logic [XLEN-1:0] file_val);
    if (src == 2'b10) return aluresult_m;
    if (src == 2'b01) return result_w;
    return file_val;
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs();
    logic [1:0]      ea, eb;
    logic [XLEN-1:0] wd;
    logic            lu;
    ea = source_of(m.rs1);
    eb = source_of(m.rs2);
    wd = value_of(eb, m.rd2);
    lu = FWD && (m.ctrl[3:2] == 2'b01) && (m.rd != 5'd0) && (m.rd == rs1_d || m.rd == rs2_d);
    check("fwd_a", fwd_a, ea);
    check("fwd_b", fwd_b, eb);
    check("srca_e", srca_e, value_of(ea, m.rd1));
    check("writedata_e", writedata_e, wd);
    check("srcb_e", srcb_e, m.alusrc ? m.imm : wd);
    check("alucontrol_e", alucontrol_e, m.alu);
    check("ctrl_e", ctrl_e, m.ctrl);
    check("rd_e", rd_e, m.rd);
    check("pc_e", pc_e, m.pc);
    check("pcplus4_e", pcplus4_e, m.pcp4);
    check("pctarget_e", pctarget_e, (m.pc + m.imm) % (64'd1 << XLEN));
    check("loaduse_stall", loaduse_stall, lu);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst || flush_e) m = bubble();
    else if (!stall_e) begin
      m.rd1 = rd1_d; m.rd2 = rd2_d; m.imm = imm_d; m.pc = pc_d; m.pcp4 = pcplus4_d;
      m.rs1 = rs1_d; m.rs2 = rs2_d; m.rd = rd_d; m.alu = alucontrol_d;
      m.alusrc = alusrc_d; m.ctrl = ctrl_d;
    end
    #1;
  endtask

  task automatic randomize_d(input int reg_range);
    rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pc_d = $urandom;
    pcplus4_d = pc_d + 4;
    rs1_d = 5'($urandom_range(reg_range)); rs2_d = 5'($urandom_range(reg_range));
    rd_d = 5'($urandom_range(reg_range));
    alucontrol_d = 3'($urandom); alusrc_d = 1'($urandom); ctrl_d = 6'($urandom);
  endtask

  task automatic randomize_fwd(input int reg_range);
    aluresult_m = $urandom; result_w = $urandom;
    rd_m = 5'($urandom_range(reg_range)); rd_w = 5'($urandom_range(reg_range));
    regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
  endtask

  task automatic quiet_fwd();
    aluresult_m = '0; result_w = '0; rd_m = '0; rd_w = '0;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
  endtask

  initial begin
    stall_e = 1'b0; flush_e = 1'b0;
    randomize_d(31);
    randomize_fwd(31);
    m = bubble();

    // Reset is visible before any clock edge.
    rst = 1'b1;
    #2;
    check_outputs();
    check("reset_srca", srca_e, '0);
    check("reset_ctrl", ctrl_e, '0);
    check("reset_pctarget", pctarget_e, '0);
    check("reset_loaduse", loaduse_stall, 1'b0);
    tick();
    rst = 1'b0;
    #1;

    // MEM forward on operand a.
    quiet_fwd();
    randomize_d(31);
    rs1_d = 5'd5; rd1_d = 32'h1111; rs2_d = 5'd9; ctrl_d = '0;
    tick();
    rd_m = 5'd5; regwrite_m = 1'b1; aluresult_m = 32'h1234;
    #1;
    check_outputs();
    check("mem_fwd_srca", srca_e, FWD ? 32'h1234 : 32'h1111);

    // MEM and WB both match operand b; MEM wins.
    quiet_fwd();
    randomize_d(31);
    rs1_d = 5'd1; rs2_d = 5'd7; rd2_d = 32'h2222; alusrc_d = 1'b0; ctrl_d = '0;
    tick();
    rd_m = 5'd7; rd_w = 5'd7; regwrite_m = 1'b1; regwrite_w = 1'b1;
    aluresult_m = 32'hA; result_w = 32'hB;
    #1;
    check_outputs();
    check("double_srcb", srcb_e, FWD ? 32'hA : 32'h2222);
    check("double_fwd_b", fwd_b, FWD ? 2'b10 : 2'b00);

    // x0 is never forwarded.
    quiet_fwd();
    randomize_d(31);
    rs1_d = 5'd0; rd1_d = 32'h5A5A; ctrl_d = '0;
    tick();
    rd_m = 5'd0; regwrite_m = 1'b1; aluresult_m = 32'hDEAD;
    #1;
    check_outputs();
    check("x0_srca", srca_e, 32'h5A5A);

    // Load-use hazard, then a flush bubbles the slot.
    quiet_fwd();
    randomize_d(31);
    ctrl_d = 6'b100100; rd_d = 5'd3;
    tick();
    rs1_d = 5'd8; rs2_d = 5'd3;
    #1;
    check_outputs();
    check("loaduse_hit", loaduse_stall, FWD);
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    #1;
    check_outputs();
    check("flush_ctrl", ctrl_e, '0);
    check("flush_rd", rd_e, '0);

    // Flush beats stall; stall alone holds; PC target wraps.
    randomize_d(31);
    tick();
    stall_e = 1'b1; flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    #1;
    check_outputs();
    check("collide_pc", pc_e, '0);
    stall_e = 1'b0;
    pc_d = 32'hFFFF_FFFC; imm_d = 32'd8;
    tick();
    stall_e = 1'b1; pc_d = 32'h1000; imm_d = 32'd4;
    tick();
    #1;
    check_outputs();
    check("stall_pc", pc_e, 32'hFFFF_FFFC);
    check("wrap_pctarget", pctarget_e, 32'h0000_0004);
    stall_e = 1'b0;

    // Reset in the middle of an instruction, then the next edge captures.
    randomize_d(31);
    ctrl_d = 6'h3F; rd_d = 5'd12;
    tick();
    rst = 1'b1;
    m = bubble();
    #1;
    check_outputs();
    check("midrst_ctrl", ctrl_e, '0);
    rst = 1'b0;
    randomize_d(31);
    pc_d = 32'h0000_0400;
    #1;
    tick();
    check_outputs();
    check("post_rst_pc", pc_e, 32'h0000_0400);

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      randomize_d(4);
      randomize_fwd(4);
      stall_e = ($urandom_range(3) == 0);
      flush_e = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) ctrl_d[3:2] = 2'b01;
      #1;
      check_outputs();
      tick();
    end
    stall_e = 1'b0; flush_e = 1'b0;
    #1;
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
